// File: rtl/axi_pkg.sv
// Shared AXI4-Lite types for the initiator adapter: response codes and FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_response_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQUEST,
    W_RESPONSE
  } axi_write_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDRESS,
    R_DATA
  } axi_read_state_t;

endpackage

// File: rtl/axi_read_interface.sv
// AXI4-Lite read channels (AR, R) with initiator and target views.
interface axi_read_interface;
  import axi_pkg::*;

  logic [31:0]   ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  axi_response_t RRESP;
  logic          RVALID;
  logic          RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_write_interface.sv
// AXI4-Lite write channels (AW, W, B) with initiator and target views.
interface axi_write_interface;
  import axi_pkg::*;

  logic [31:0]   AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  axi_response_t BRESP;
  logic          BVALID;
  logic          BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi_master.sv
// AXI4-Lite initiator: turns single-beat start/done requests from a core into
// AW/W/B and AR/R handshakes. Write and read paths run independently, one
// transaction outstanding on each.
module axi_master
  import axi_pkg::*;
(
  input  logic                      axi_ACLK,
  input  logic                      axi_ARESETN,
  axi_write_interface.master        write_channel,
  axi_read_interface.master         read_channel,
  input  logic                      write_start_i,
  input  logic [31:0]               write_address_i,
  input  logic [31:0]               write_data_i,
  input  logic [3:0]                write_strobe_i,
  output logic                      write_done_o,
  output logic                      write_error_o,
  output logic                      write_cts_o,
  input  logic                      read_start_i,
  input  logic [31:0]               read_address_i,
  output logic [31:0]               read_data_o,
  output logic                      read_done_o,
  output logic                      read_error_o,
  output logic                      read_cts_o
);

  axi_write_state_t wstate_q;
  logic [31:0]      awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             awvalid_q;
  logic             wvalid_q;
  logic             bready_q;
  logic             write_done_q;
  logic             write_error_q;

  axi_read_state_t  rstate_q;
  logic [31:0]      araddr_q;
  logic             arvalid_q;
  logic             rready_q;
  logic [31:0]      read_data_q;
  logic             read_done_q;
  logic             read_error_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_complete, w_complete;

  // Handshake strobes; an AW or W channel counts as complete once its VALID has
  // already dropped or it is handshaking this cycle.
  assign aw_hs       = awvalid_q & write_channel.AWREADY;
  assign w_hs        = wvalid_q  & write_channel.WREADY;
  assign b_hs        = bready_q  & write_channel.BVALID;
  assign ar_hs       = arvalid_q & read_channel.ARREADY;
  assign r_hs        = rready_q  & read_channel.RVALID;
  assign aw_complete = ~awvalid_q | aw_hs;
  assign w_complete  = ~wvalid_q  | w_hs;

  assign write_channel.AWADDR  = awaddr_q;
  assign write_channel.AWVALID = awvalid_q;
  assign write_channel.WDATA   = wdata_q;
  assign write_channel.WSTRB   = wstrb_q;
  assign write_channel.WVALID  = wvalid_q;
  assign write_channel.BREADY  = bready_q;
  assign read_channel.ARADDR   = araddr_q;
  assign read_channel.ARVALID  = arvalid_q;
  assign read_channel.RREADY   = rready_q;

  assign write_done_o  = write_done_q;
  assign write_error_o = write_error_q;
  assign write_cts_o   = (wstate_q == W_IDLE);
  assign read_data_o   = read_data_q;
  assign read_done_o   = read_done_q;
  assign read_error_o  = read_error_q;
  assign read_cts_o    = (rstate_q == R_IDLE);

  // Write FSM: latch the request, drive AW and W until each handshakes, then collect B.
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      wstate_q      <= W_IDLE;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      write_done_q  <= 1'b0;
      write_error_q <= 1'b0;
    end else begin
      write_done_q <= 1'b0;
      case (wstate_q)
        W_IDLE: begin
          if (write_start_i) begin
            awaddr_q  <= write_address_i;
            wdata_q   <= write_data_i;
            wstrb_q   <= write_strobe_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wstate_q  <= W_REQUEST;
          end
        end
        W_REQUEST: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (aw_complete && w_complete) begin
            bready_q <= 1'b1;
            wstate_q <= W_RESPONSE;
          end
        end
        W_RESPONSE: begin
          if (b_hs) begin
            bready_q      <= 1'b0;
            write_error_q <= (write_channel.BRESP != OKAY);
            write_done_q  <= 1'b1;
            wstate_q      <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch the address, drive AR until accepted, then take one R beat.
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      rstate_q     <= R_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      read_done_q <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          if (read_start_i) begin
            araddr_q  <= read_address_i;
            arvalid_q <= 1'b1;
            rstate_q  <= R_ADDRESS;
          end
        end
        R_ADDRESS: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            read_data_q  <= read_channel.RDATA;
            read_error_q <= (read_channel.RRESP != OKAY);
            read_done_q  <= 1'b1;
            rready_q     <= 1'b0;
            rstate_q     <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

`ifdef SV_ASSERTION
  // A VALID that has not yet handshaken must stay high with a stable payload.
  property p_valid_hold(logic v, logic r);
    @(posedge axi_ACLK) disable iff (!axi_ARESETN) (v && !r) |=> v;
  endproperty

  property p_payload_stable(logic v, logic r, logic [31:0] p);
    @(posedge axi_ACLK) disable iff (!axi_ARESETN) (v && !r) |=> $stable(p);
  endproperty

  a_aw_hold:   assert property (p_valid_hold(awvalid_q, write_channel.AWREADY));
  a_w_hold:    assert property (p_valid_hold(wvalid_q,  write_channel.WREADY));
  a_ar_hold:   assert property (p_valid_hold(arvalid_q, read_channel.ARREADY));
  a_aw_stable: assert property (p_payload_stable(awvalid_q, write_channel.AWREADY, awaddr_q));
  a_w_stable:  assert property (p_payload_stable(wvalid_q,  write_channel.WREADY,  wdata_q));
  a_ar_stable: assert property (p_payload_stable(arvalid_q, read_channel.ARREADY, araddr_q));
`endif

endmodule

// File: tb/tb_axi_master.sv
// Self-checking bench for axi_master: a programmable-latency AXI-Lite target
// model plus a scoreboard of expected done/error/data results.
module tb_axi_master;
  import axi_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rdExp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_start_i;
  logic [31:0] write_address_i;
  logic [31:0] write_data_i;
  logic [3:0]  write_strobe_i;
  logic        write_done_o;
  logic        write_error_o;
  logic        write_cts_o;
  logic        read_start_i;
  logic [31:0] read_address_i;
  logic [31:0] read_data_o;
  logic        read_done_o;
  logic        read_error_o;
  logic        read_cts_o;

  axi_write_interface wr ();
  axi_read_interface  rd ();

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int startCyc   = 0;
  int wrDoneCount = 0;
  int rdDoneCount = 0;

  // Target model configuration, set by the stimulus thread between transactions.
  int            awDelay = 0;
  int            wDelay  = 0;
  int            arDelay = 0;
  int            bDelay  = 1;
  int            rDelay  = 1;
  axi_response_t bResp   = OKAY;
  axi_response_t rResp   = OKAY;
  logic [31:0]   rData   = '0;

  bit     wrQ[$];
  rdExp_t rdQ[$];

  axi_master dut (
    .axi_ACLK        (clk),
    .axi_ARESETN     (rst_n),
    .write_channel   (wr),
    .read_channel    (rd),
    .write_start_i   (write_start_i),
    .write_address_i (write_address_i),
    .write_data_i    (write_data_i),
    .write_strobe_i  (write_strobe_i),
    .write_done_o    (write_done_o),
    .write_error_o   (write_error_o),
    .write_cts_o     (write_cts_o),
    .read_start_i    (read_start_i),
    .read_address_i  (read_address_i),
    .read_data_o     (read_data_o),
    .read_done_o     (read_done_o),
    .read_error_o    (read_error_o),
    .read_cts_o      (read_cts_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of start requests and queue the results the target will produce.
  task automatic applyStimulus(input logic wrStart, input logic [31:0] wrAddr, input logic [31:0] wrData,
                               input logic [3:0] wrStrb, input logic rdStart, input logic [31:0] rdAddr,
                               input bit wrAccept, input bit rdAccept);
    rdExp_t e;
    write_start_i   = wrStart;
    write_address_i = wrAddr;
    write_data_i    = wrData;
    write_strobe_i  = wrStrb;
    read_start_i    = rdStart;
    read_address_i  = rdAddr;
    if (wrAccept || rdAccept) startCyc = cyc;
    if (wrAccept) wrQ.push_back(bResp != OKAY);
    if (rdAccept) begin
      e.data = rData;
      e.err  = (rResp != OKAY);
      rdQ.push_back(e);
    end
    @(negedge clk);
    write_start_i = 1'b0;
    read_start_i  = 1'b0;
  endtask

  task automatic waitUntil(input int n);
    while (cyc - startCyc < n) @(negedge clk);
  endtask

  task automatic waitDone(input bit isWrite, input int maxCycles, input string tag, output int doneAt);
    int n = 0;
    doneAt = -1;
    while (n < maxCycles) begin
      if ((isWrite && write_done_o) || (!isWrite && read_done_o)) begin
        doneAt = cyc - startCyc;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (doneAt < 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Target model: READY after a programmed wait on AW/W/AR, B/R VALID a programmed
  // number of cycles after the initiator raises READY, held until accepted.
  int awCnt = 0, wCnt = 0, arCnt = 0, bCnt = 0, rCnt = 0;
  always @(negedge clk) begin
    if (wr.AWVALID) begin wr.AWREADY = (awCnt >= awDelay); awCnt++; end
    else begin wr.AWREADY = 1'b0; awCnt = 0; end
    if (wr.WVALID) begin wr.WREADY = (wCnt >= wDelay); wCnt++; end
    else begin wr.WREADY = 1'b0; wCnt = 0; end
    if (rd.ARVALID) begin rd.ARREADY = (arCnt >= arDelay); arCnt++; end
    else begin rd.ARREADY = 1'b0; arCnt = 0; end
    if (wr.BREADY) begin wr.BVALID = (bCnt >= bDelay); wr.BRESP = bResp; bCnt++; end
    else begin wr.BVALID = 1'b0; wr.BRESP = OKAY; bCnt = 0; end
    if (rd.RREADY) begin rd.RVALID = (rCnt >= rDelay); rd.RDATA = rData; rd.RRESP = rResp; rCnt++; end
    else begin rd.RVALID = 1'b0; rd.RDATA = '0; rd.RRESP = OKAY; rCnt = 0; end
  end

  // Monitor: scoreboard completions, single-cycle done pulses, VALID/payload hold.
  bit          holdAw = 0, holdW = 0, holdAr = 0, prevWrDone = 0, prevRdDone = 0;
  logic [31:0] lastAwAddr = '0, lastWData = '0, lastArAddr = '0;
  always @(negedge clk) begin
    bit     we;
    rdExp_t re;
    #2;
    if (!rst_n) begin
      holdAw = 0; holdW = 0; holdAr = 0; prevWrDone = 0; prevRdDone = 0;
    end else begin
      if (holdAw) begin
        checkOutput("aw_valid_hold", 32'(wr.AWVALID), 32'd1);
        checkOutput("aw_addr_stable", wr.AWADDR, lastAwAddr);
      end
      if (holdW) begin
        checkOutput("w_valid_hold", 32'(wr.WVALID), 32'd1);
        checkOutput("w_data_stable", wr.WDATA, lastWData);
      end
      if (holdAr) begin
        checkOutput("ar_valid_hold", 32'(rd.ARVALID), 32'd1);
        checkOutput("ar_addr_stable", rd.ARADDR, lastArAddr);
      end
      holdAw = wr.AWVALID && !wr.AWREADY; lastAwAddr = wr.AWADDR;
      holdW  = wr.WVALID  && !wr.WREADY;  lastWData  = wr.WDATA;
      holdAr = rd.ARVALID && !rd.ARREADY; lastArAddr = rd.ARADDR;
      if (write_done_o) begin
        wrDoneCount++;
        checkOutput("wr_done_single", 32'(prevWrDone), 32'd0);
        if (wrQ.size() == 0) checkOutput("wr_unexpected_done", 32'd1, 32'd0);
        else begin
          we = wrQ.pop_front();
          checkOutput("wr_error", 32'(write_error_o), 32'(we));
        end
      end
      if (read_done_o) begin
        rdDoneCount++;
        checkOutput("rd_done_single", 32'(prevRdDone), 32'd0);
        if (rdQ.size() == 0) checkOutput("rd_unexpected_done", 32'd1, 32'd0);
        else begin
          re = rdQ.pop_front();
          checkOutput("rd_data", read_data_o, re.data);
          checkOutput("rd_error", 32'(read_error_o), 32'(re.err));
        end
      end
      prevWrDone = write_done_o;
      prevRdDone = read_done_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneAt;
    int wrBefore, rdBefore;

    rst_n = 1'b0;
    write_start_i = 1'b0; write_address_i = '0; write_data_i = '0; write_strobe_i = '0;
    read_start_i  = 1'b0; read_address_i  = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_awvalid", 32'(wr.AWVALID), 32'd0);
    checkOutput("rst_wvalid",  32'(wr.WVALID),  32'd0);
    checkOutput("rst_bready",  32'(wr.BREADY),  32'd0);
    checkOutput("rst_arvalid", 32'(rd.ARVALID), 32'd0);
    checkOutput("rst_rready",  32'(rd.RREADY),  32'd0);
    checkOutput("rst_awaddr",  wr.AWADDR, 32'd0);
    checkOutput("rst_rdata",   read_data_o, 32'd0);
    checkOutput("rst_wcts",    32'(write_cts_o), 32'd1);
    checkOutput("rst_rcts",    32'(read_cts_o),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write, always-ready target");
    applyStimulus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("t1_awvalid", 32'(wr.AWVALID), 32'd1);
    checkOutput("t1_wvalid",  32'(wr.WVALID),  32'd1);
    checkOutput("t1_awaddr",  wr.AWADDR, 32'h8000_0010);
    checkOutput("t1_wdata",   wr.WDATA,  32'hDEAD_BEEF);
    checkOutput("t1_wstrb",   32'(wr.WSTRB), 32'hF);
    checkOutput("t1_cts_busy", 32'(write_cts_o), 32'd0);
    waitDone(1'b1, 20, "t1_done", doneAt);
    checkOutput("t1_done_cycle", doneAt, 32'd4);
    checkOutput("t1_cts_on_done", 32'(write_cts_o), 32'd1);
    repeat (2) @(negedge clk);

    $display("[TB] write, WREADY late, DECERR response");
    wDelay = 4; bResp = DECERR;
    applyStimulus(1'b1, 32'h0000_0044, 32'h0102_0304, 4'h5, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("t2_awvalid_c1", 32'(wr.AWVALID), 32'd1);
    checkOutput("t2_wvalid_c1",  32'(wr.WVALID),  32'd1);
    waitUntil(2);
    checkOutput("t2_awvalid_c2", 32'(wr.AWVALID), 32'd0);
    checkOutput("t2_wvalid_c2",  32'(wr.WVALID),  32'd1);
    waitUntil(5);
    checkOutput("t2_wvalid_c5", 32'(wr.WVALID), 32'd1);
    checkOutput("t2_bready_c5", 32'(wr.BREADY), 32'd0);
    waitUntil(6);
    checkOutput("t2_wvalid_c6", 32'(wr.WVALID), 32'd0);
    checkOutput("t2_bready_c6", 32'(wr.BREADY), 32'd1);
    waitDone(1'b1, 20, "t2_done", doneAt);
    checkOutput("t2_done_cycle", doneAt, 32'd8);
    wDelay = 0; bResp = OKAY;
    repeat (2) @(negedge clk);

    $display("[TB] read with SLVERR");
    rData = 32'h1234_5678; rResp = SLVERR;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    checkOutput("t3_arvalid_c1", 32'(rd.ARVALID), 32'd1);
    checkOutput("t3_araddr",     rd.ARADDR, 32'h0000_0100);
    checkOutput("t3_rcts_busy",  32'(read_cts_o), 32'd0);
    waitUntil(2);
    checkOutput("t3_arvalid_c2", 32'(rd.ARVALID), 32'd0);
    checkOutput("t3_rready_c2",  32'(rd.RREADY),  32'd1);
    waitDone(1'b0, 20, "t3_done", doneAt);
    checkOutput("t3_done_cycle", doneAt, 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("t3_data_held", read_data_o, 32'h1234_5678);
    rResp = OKAY;

    $display("[TB] read start while busy, write start on done pulse");
    rData = 32'hCAFE_F00D; rDelay = 3;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    waitUntil(2);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    waitDone(1'b0, 20, "t4_rd_done", doneAt);
    checkOutput("t4_rd_done_cycle", doneAt, 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_no_second_ar", 32'(rd.ARVALID), 32'd0);
    end
    checkOutput("t4_araddr_kept", rd.ARADDR, 32'h0000_0200);
    rDelay = 1;
    applyStimulus(1'b1, 32'h0000_0010, 32'h1111_1111, 4'h3, 1'b0, 32'd0, 1'b1, 1'b0);
    waitDone(1'b1, 20, "t4_w1_done", doneAt);
    applyStimulus(1'b1, 32'h0000_0020, 32'h2222_2222, 4'hC, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("t4_w2_awvalid", 32'(wr.AWVALID), 32'd1);
    checkOutput("t4_w2_awaddr",  wr.AWADDR, 32'h0000_0020);
    checkOutput("t4_w2_wstrb",   32'(wr.WSTRB), 32'hC);
    waitDone(1'b1, 20, "t4_w2_done", doneAt);
    checkOutput("t4_w2_done_cycle", doneAt, 32'd4);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-transaction");
    awDelay = 1000; wDelay = 1000; arDelay = 1000;
    applyStimulus(1'b1, 32'h0000_0040, 32'h4444_4444, 4'hF, 1'b1, 32'h0000_0050, 1'b1, 1'b1);
    waitUntil(2);
    checkOutput("t5_awvalid_pre", 32'(wr.AWVALID), 32'd1);
    checkOutput("t5_arvalid_pre", 32'(rd.ARVALID), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_awvalid_async", 32'(wr.AWVALID), 32'd0);
    checkOutput("t5_wvalid_async",  32'(wr.WVALID),  32'd0);
    checkOutput("t5_arvalid_async", 32'(rd.ARVALID), 32'd0);
    wrQ.delete();
    rdQ.delete();
    repeat (2) @(negedge clk);
    awDelay = 0; wDelay = 0; arDelay = 0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_wcts", 32'(write_cts_o), 32'd1);
    checkOutput("t5_rcts", 32'(read_cts_o),  32'd1);
    wrBefore = wrDoneCount;
    rdBefore = rdDoneCount;
    repeat (8) @(negedge clk);
    checkOutput("t5_no_wr_done", wrDoneCount - wrBefore, 32'd0);
    checkOutput("t5_no_rd_done", rdDoneCount - rdBefore, 32'd0);
    checkOutput("t5_awvalid_idle", 32'(wr.AWVALID), 32'd0);

    $display("[TB] concurrent write and read, B stalled");
    bDelay = 10; bResp = EXOKAY; rData = 32'h0BAD_F00D;
    applyStimulus(1'b1, 32'h0000_0060, 32'h6666_6666, 4'hF, 1'b1, 32'h0000_0070, 1'b1, 1'b1);
    waitDone(1'b0, 20, "t6_rd_done", doneAt);
    checkOutput("t6_rd_done_cycle", doneAt, 32'd4);
    checkOutput("t6_bready_c4", 32'(wr.BREADY), 32'd1);
    for (int c = 5; c <= 12; c++) begin
      waitUntil(c);
      checkOutput("t6_bready_held", 32'(wr.BREADY), 32'd1);
    end
    waitDone(1'b1, 20, "t6_wr_done", doneAt);
    checkOutput("t6_wr_done_cycle", doneAt, 32'd13);
    checkOutput("t6_bready_after", 32'(wr.BREADY), 32'd0);
    bDelay = 1; bResp = OKAY;
    repeat (3) @(negedge clk);

    checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
    checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
